mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 256-bit DDR user port (mem_valid_data/mem_ready_data) between two requesters:
//  port 0 = DVI frame loader, port 1 = CPU/NPU data path. Round-robin, one outstanding transaction.
//  Sits between the requesters and the memory controller; fully registered toward memory.
// PARAMETERS
//  ADDR_W       28    memory address width
//  DATA_W       256   memory data width
//  TIMEOUT_CYC  1024  watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN)
// PORTS
//  clk             in   1       single clock for all logic (100 MHz domain)
//  rst             in   1       synchronous, active-high reset
//  rq0_valid       in   1       port 0 request; held with rq0_rw/addr/wdata until rq0_done
//  rq0_rw          in   1       1 = write, 0 = read
//  rq0_addr        in   ADDR_W  port 0 address
//  rq0_wdata       in   DATA_W  port 0 write data
//  rq0_done        out  1       one-cycle completion pulse
//  rq1_*           same set for port 1 (rq1_valid, rq1_rw, rq1_addr, rq1_wdata, rq1_done)
//  rdata           out  DATA_W  read data; valid in rqN_done cycle of a read
//  err             out  1       with rqN_done: transaction aborted by watchdog
//  mem_valid_data  out  1       request to memory; held until mem_ready_data
//  mem_rw_data     out  1       1 = write
//  mem_data_addr   out  ADDR_W  memory address
//  data_wr         out  DATA_W  memory write data
//  data_rd         in   DATA_W  memory read data, valid with mem_ready_data
//  mem_ready_data  in   1       one-cycle completion from memory
// BEHAVIOUR
//  - Reset (sync, high): all outputs 0; state IDLE; last_grant = 1 (port 0 wins first tie); watchdog = 0.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: if any rqN_valid, pick a winner, latch its rw/addr/wdata into the mem_* registers,
//          set mem_valid_data = 1 at the next edge, go to BUSY.
//    BUSY: hold mem_* stable. On mem_ready_data, register data_rd into rdata (reads; writes leave
//          rdata unchanged), drop mem_valid_data, pulse the winner's rqN_done, go to DONE.
//    DONE: one cycle in which requests are ignored. The requester drops or changes rqN_valid at the
//          edge ending its done cycle; the next IDLE sample sees the new value, so no duplicate issue.
//  - Latency: rqN_valid sampled at edge t -> mem_valid_data high after t. mem_ready_data sampled at
//    edge r -> rqN_done and rdata after r. Back-to-back turnaround is 2 idle cycles.
//  - Arbitration: one valid wins alone. Both valid: grant != last_grant, then last_grant = grant.
//    A requester asserting valid while BUSY waits; there is no preemption.
//  - mem_ready_data outside BUSY is ignored. rqN_valid dropped while BUSY does not cancel the transaction.
//  - rst mid-transaction: abandons it at the next edge. No rqN_done is issued. The memory side is
//    reset with the same rst.
// CONFIGURATION
//  - MEM_ARB_TIMEOUT_EN defined: a counter runs in BUSY and clears on leaving BUSY.
//    - When it reaches TIMEOUT_CYC-1 without mem_ready_data: drop mem_valid_data, pulse rqN_done
//      with err = 1 and rdata = 0, go to DONE.
//    - A mem_ready_data arriving in the same cycle as expiry wins: normal completion, err = 0.
//  - Not defined: no counter; BUSY waits indefinitely; err tied 0.
// STRUCTURE
//  - Package mem_arb_pkg: state encoding (IDLE/BUSY/DONE), port-index constants, default widths.
//  - Sub-module rr_arbiter2: combinational 2-way round-robin pick from {rq1_valid, rq0_valid}
//    and last_grant -> grant index plus any_req.
// TESTING
//  1 Single read, port 0: addr 28'h0000040; memory answers after 5 cycles with data_rd = 256'hA5..A5
//    -> rq0_done 1 cycle, rdata = A5..A5, mem_valid_data high exactly 5 cycles.
//  2 Simultaneous requests both held for 4 transactions -> grants 0,1,0,1. mem_data_addr matches
//    each grant's address. No double issue.
//  3 Port 1 write (rw = 1, wdata = 256'h1234) while port 0 is BUSY -> port 1 waits, then issues.
//    data_wr = 256'h1234, mem_rw_data = 1.
//  4 rst asserted 2 cycles into BUSY -> next cycle all outputs 0. Stray mem_ready_data afterwards
//    is ignored; no rqN_done.
//  5 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC = 16, memory never ready -> done + err after 16 BUSY cycles,
//    rdata = 0. Next request proceeds normally.
//  6 mem_ready_data asserted while IDLE -> no outputs change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port DDR user-port arbiter.
//  - arb_state_e : arbiter FSM encoding (idle / busy / done)
//  - Port0/Port1 : requester index constants used as grant values
//  - Def*        : default address/data widths and watchdog limit
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } arb_state_e;

   localparam logic Port0 = 1'b0;  // DVI frame loader
   localparam logic Port1 = 1'b1;  // CPU/NPU data path

   localparam int unsigned DefAddrW      = 28;
   localparam int unsigned DefDataW      = 256;
   localparam int unsigned DefTimeoutCyc = 1024;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
//  req_i        in  2  {port 1 valid, port 0 valid}
//  last_grant_i in  1  port granted by the previous arbitration
//  grant_o      out 1  winning port index (meaningful only with any_req_o)
//  any_req_o    out 1  at least one request pending
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       grant_o,
   output logic       any_req_o
);

   always_comb begin
      any_req_o = |req_i;
      unique case (req_i)
         2'b01:   grant_o = Port0;
         2'b10:   grant_o = Port1;
         // Tie: the port that did not win last time goes first.
         2'b11:   grant_o = ~last_grant_i;
         default: grant_o = last_grant_i;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one DDR user port between two requesters (0 = DVI loader, 1 = CPU/NPU).
// Round-robin, a single outstanding transaction, all memory-side outputs registered.
//  clk, rst                    clock, synchronous active-high reset
//  rqN_valid/rw/addr/wdata     request N, held until rqN_done (N = 0, 1)
//  rqN_done                    one-cycle completion pulse for request N
//  rdata, err                  read data / watchdog abort flag, valid with rqN_done
//  mem_valid_data ... data_wr  request toward memory, held until mem_ready_data
//  data_rd, mem_ready_data     memory read data and one-cycle completion
// Optional: define MEM_ARB_TIMEOUT_EN to enable the BUSY watchdog (TIMEOUT_CYC cycles);
// otherwise BUSY waits indefinitely and err is tied low.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = DefAddrW,
   parameter int unsigned DATA_W      = DefDataW,
   parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rq0_valid,
   input  logic              rq0_rw,
   input  logic [ADDR_W-1:0] rq0_addr,
   input  logic [DATA_W-1:0] rq0_wdata,
   output logic              rq0_done,
   input  logic              rq1_valid,
   input  logic              rq1_rw,
   input  logic [ADDR_W-1:0] rq1_addr,
   input  logic [DATA_W-1:0] rq1_wdata,
   output logic              rq1_done,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              mem_valid_data,
   output logic              mem_rw_data,
   output logic [ADDR_W-1:0] mem_data_addr,
   output logic [DATA_W-1:0] data_wr,
   input  logic [DATA_W-1:0] data_rd,
   input  logic              mem_ready_data
);

   arb_state_e        state_q;
   logic              last_grant_q;
   logic              grant_q;
   logic [1:0]        done_q;
   logic              mem_valid_q;
   logic              mem_rw_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              grant;
   logic              any_req;

   rr_arbiter2 u_rr (
      .req_i        ({rq1_valid, rq0_valid}),
      .last_grant_i (last_grant_q),
      .grant_o      (grant),
      .any_req_o    (any_req)
   );

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned WdW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [WdW-1:0] wd_q;
   logic           wd_expired;
   logic           err_q;
   assign wd_expired = (wd_q == WdW'(TIMEOUT_CYC - 1));
   assign err        = err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign err                = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         last_grant_q <= Port1;  // port 0 wins the first tie
         grant_q      <= Port0;
         done_q       <= 2'b00;
         mem_valid_q  <= 1'b0;
         mem_rw_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         rdata_q      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         wd_q         <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         done_q <= 2'b00;
`ifdef MEM_ARB_TIMEOUT_EN
         err_q  <= 1'b0;
         // Counts BUSY cycles only; any exit from BUSY returns it to zero.
         wd_q   <= (state_q == StBusy && !mem_ready_data && !wd_expired) ? wd_q + 1'b1 : '0;
`endif
         unique case (state_q)
            StIdle: begin
               if (any_req) begin
                  grant_q      <= grant;
                  last_grant_q <= grant;
                  mem_valid_q  <= 1'b1;
                  mem_rw_q     <= (grant == Port1) ? rq1_rw    : rq0_rw;
                  mem_addr_q   <= (grant == Port1) ? rq1_addr  : rq0_addr;
                  mem_wdata_q  <= (grant == Port1) ? rq1_wdata : rq0_wdata;
                  state_q      <= StBusy;
               end
            end
            StBusy: begin
               // A completion in the expiry cycle takes priority over the watchdog.
               if (mem_ready_data) begin
                  if (!mem_rw_q) rdata_q <= data_rd;
                  mem_valid_q      <= 1'b0;
                  done_q[grant_q]  <= 1'b1;
                  state_q          <= StDone;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (wd_expired) begin
                  rdata_q          <= '0;
                  err_q            <= 1'b1;
                  mem_valid_q      <= 1'b0;
                  done_q[grant_q]  <= 1'b1;
                  state_q          <= StDone;
               end
`endif
            end
            // Requester updates its valid during this cycle; ignore requests until IDLE.
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rq0_done       = done_q[0];
   assign rq1_done       = done_q[1];
   assign rdata          = rdata_q;
   assign mem_valid_data = mem_valid_q;
   assign mem_rw_data    = mem_rw_q;
   assign mem_data_addr  = mem_addr_q;
   assign data_wr        = mem_wdata_q;

endmodule
